// File: rtl/tile_loop_sequencer.sv
// tile_loop_sequencer
//   Two-level tile walker for the systolic-array datapath. The outer loop runs
//   over ifmap-channel tiles and the inner loop over weight tiles. For each tile
//   the block streams L operand beats, then drains the array pipeline for
//   PIPE_LAT cycles. Write and accumulate-read strobes come from a delay line
//   fed by the operand fetch.
//
// Ports
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  start request, accepted only in IDLE
//   stall_i                  freezes state, counters and the delay line
//   cfg_*                    loop configuration, latched when start is accepted
//   rd_en_o, w_idx_o,
//   if_idx_o                 operand fetch strobe and buffer indices
//   acc_rd_en_o,
//   acc_rd_addr_o            partial-sum read, one cycle ahead of the write
//   wr_en_o, wr_addr_o,
//   accumulate_o             result write strobe, address and accumulate flag
//   w_tile_o, if_tile_o      current tile counters
//   busy_o, done_o           run status and one-cycle completion pulse
module tile_loop_sequencer #(
   parameter int unsigned IDX_W    = 16,
   parameter int unsigned ADDR_W   = 13,
   parameter int unsigned LEN_W    = 11,
   parameter int unsigned CNT_W    = 6,
   parameter int unsigned PIPE_LAT = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic              stall_i,
   input  logic [LEN_W-1:0]  cfg_tile_len_i,
   input  logic [CNT_W-1:0]  cfg_w_tiles_i,
   input  logic [CNT_W-1:0]  cfg_if_tiles_i,
   input  logic [IDX_W-1:0]  cfg_w_stride_i,
   input  logic [IDX_W-1:0]  cfg_wc_stride_i,
   input  logic [IDX_W-1:0]  cfg_if_stride_i,
   input  logic [ADDR_W-1:0] cfg_out_stride_i,
   output logic              rd_en_o,
   output logic [IDX_W-1:0]  w_idx_o,
   output logic [IDX_W-1:0]  if_idx_o,
   output logic              acc_rd_en_o,
   output logic [ADDR_W-1:0] acc_rd_addr_o,
   output logic              wr_en_o,
   output logic [ADDR_W-1:0] wr_addr_o,
   output logic              accumulate_o,
   output logic [CNT_W-1:0]  w_tile_o,
   output logic [CNT_W-1:0]  if_tile_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned DRN_W = $clog2(PIPE_LAT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_STREAM,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e state_q, state_d;

   // Latched configuration
   logic [LEN_W-1:0]  len_q;
   logic [CNT_W-1:0]  w_tiles_q;
   logic [CNT_W-1:0]  if_tiles_q;
   logic [IDX_W-1:0]  w_stride_q;
   logic [IDX_W-1:0]  wc_stride_q;
   logic [IDX_W-1:0]  if_stride_q;
   logic [ADDR_W-1:0] out_stride_q;

   // Loop counters and incrementally maintained bases
   logic [LEN_W-1:0]  beat_q;
   logic [DRN_W-1:0]  drain_q;
   logic [CNT_W-1:0]  w_tile_q;
   logic [CNT_W-1:0]  if_tile_q;
   logic [IDX_W-1:0]  w_row_q;    // if_tile * wc_stride
   logic [IDX_W-1:0]  w_base_q;   // w_row + w_tile * w_stride
   logic [IDX_W-1:0]  if_base_q;
   logic [ADDR_W-1:0] out_base_q;

   // Last-driven values of the index/address outputs
   logic [IDX_W-1:0]  w_idx_q;
   logic [IDX_W-1:0]  if_idx_q;
   logic [ADDR_W-1:0] acc_rd_addr_q;
   logic [ADDR_W-1:0] wr_addr_q;
   logic              accum_q;

   // Write-path delay line, stage 0 is written by the fetch beat
   logic [PIPE_LAT-1:0]             dl_vld;
   logic [PIPE_LAT-1:0]             dl_acc;
   logic [PIPE_LAT-1:0][ADDR_W-1:0] dl_addr;

   logic              start_acc;
   logic              cfg_empty;
   logic              beat_last;
   logic              drain_last;
   logic              w_last;
   logic              if_last;
   logic              rd_en;
   logic              wr_en;
   logic              acc_rd_en;
   logic [IDX_W-1:0]  cur_w_idx;
   logic [IDX_W-1:0]  cur_if_idx;
   logic [ADDR_W-1:0] cur_out;

   always_comb begin
      start_acc  = (state_q == S_IDLE) && start_i;
      cfg_empty  = (cfg_tile_len_i == '0) || (cfg_w_tiles_i == '0) ||
                   (cfg_if_tiles_i == '0);
      beat_last  = (beat_q == len_q - LEN_W'(1));
      drain_last = (drain_q == DRN_W'(PIPE_LAT - 1));
      w_last     = (w_tile_q == w_tiles_q - CNT_W'(1));
      if_last    = (if_tile_q == if_tiles_q - CNT_W'(1));

      cur_w_idx  = w_base_q + IDX_W'(beat_q);
      cur_if_idx = if_base_q + IDX_W'(beat_q);
      cur_out    = out_base_q + ADDR_W'(beat_q);

      rd_en      = (state_q == S_STREAM) && !stall_i;
      wr_en      = dl_vld[PIPE_LAT-1] && !stall_i;
      // Read stage sits one stage ahead of the write stage
      acc_rd_en  = dl_vld[PIPE_LAT-2] && dl_acc[PIPE_LAT-2] && !stall_i;
   end

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; stall_i has no effect in IDLE
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d = cfg_empty ? S_DONE : S_STREAM;
            end
         end
         S_STREAM: begin
            if (!stall_i && beat_last) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (!stall_i && drain_last) begin
               state_d = (w_last && if_last) ? S_DONE : S_STREAM;
            end
         end
         S_DONE: begin
            if (!stall_i) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Configuration, loop counters and bases
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         len_q        <= '0;
         w_tiles_q    <= '0;
         if_tiles_q   <= '0;
         w_stride_q   <= '0;
         wc_stride_q  <= '0;
         if_stride_q  <= '0;
         out_stride_q <= '0;
         beat_q       <= '0;
         drain_q      <= '0;
         w_tile_q     <= '0;
         if_tile_q    <= '0;
         w_row_q      <= '0;
         w_base_q     <= '0;
         if_base_q    <= '0;
         out_base_q   <= '0;
      end else if (start_acc) begin
         len_q        <= cfg_tile_len_i;
         w_tiles_q    <= cfg_w_tiles_i;
         if_tiles_q   <= cfg_if_tiles_i;
         w_stride_q   <= cfg_w_stride_i;
         wc_stride_q  <= cfg_wc_stride_i;
         if_stride_q  <= cfg_if_stride_i;
         out_stride_q <= cfg_out_stride_i;
         beat_q       <= '0;
         drain_q      <= '0;
         w_tile_q     <= '0;
         if_tile_q    <= '0;
         w_row_q      <= '0;
         w_base_q     <= '0;
         if_base_q    <= '0;
         out_base_q   <= '0;
      end else if (!stall_i) begin
         unique case (state_q)
            S_STREAM: begin
               beat_q <= beat_last ? '0 : beat_q + LEN_W'(1);
            end
            S_DRAIN: begin
               drain_q <= drain_last ? '0 : drain_q + DRN_W'(1);
               // Bases advance at the end of the drain so the next tile's
               // first beat sees them; the delay line already holds the
               // addresses of the finished tile.
               if (drain_last) begin
                  if (w_last) begin
                     w_tile_q   <= '0;
                     out_base_q <= '0;
                     if (if_last) begin
                        if_tile_q <= '0;
                        w_row_q   <= '0;
                        w_base_q  <= '0;
                        if_base_q <= '0;
                     end else begin
                        if_tile_q <= if_tile_q + CNT_W'(1);
                        w_row_q   <= w_row_q + wc_stride_q;
                        w_base_q  <= w_row_q + wc_stride_q;
                        if_base_q <= if_base_q + if_stride_q;
                     end
                  end else begin
                     w_tile_q   <= w_tile_q + CNT_W'(1);
                     w_base_q   <= w_base_q + w_stride_q;
                     out_base_q <= out_base_q + out_stride_q;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Write-path delay line
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dl_vld  <= '0;
         dl_acc  <= '0;
         dl_addr <= '0;
      end else if (!stall_i) begin
         dl_vld  <= {dl_vld[PIPE_LAT-2:0], rd_en};
         dl_acc  <= {dl_acc[PIPE_LAT-2:0], (if_tile_q != '0)};
         dl_addr <= {dl_addr[PIPE_LAT-2:0], cur_out};
      end
   end

   // Hold registers for the index/address outputs
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_idx_q       <= '0;
         if_idx_q      <= '0;
         acc_rd_addr_q <= '0;
         wr_addr_q     <= '0;
         accum_q       <= 1'b0;
      end else begin
         if (rd_en) begin
            w_idx_q  <= cur_w_idx;
            if_idx_q <= cur_if_idx;
         end
         if (acc_rd_en) begin
            acc_rd_addr_q <= dl_addr[PIPE_LAT-2];
         end
         if (wr_en) begin
            wr_addr_q <= dl_addr[PIPE_LAT-1];
            accum_q   <= dl_acc[PIPE_LAT-1];
         end
      end
   end

   always_comb begin
      rd_en_o       = rd_en;
      w_idx_o       = rd_en ? cur_w_idx : w_idx_q;
      if_idx_o      = rd_en ? cur_if_idx : if_idx_q;
      acc_rd_en_o   = acc_rd_en;
      acc_rd_addr_o = acc_rd_en ? dl_addr[PIPE_LAT-2] : acc_rd_addr_q;
      wr_en_o       = wr_en;
      wr_addr_o     = wr_en ? dl_addr[PIPE_LAT-1] : wr_addr_q;
      accumulate_o  = wr_en ? dl_acc[PIPE_LAT-1] : accum_q;
      w_tile_o      = w_tile_q;
      if_tile_o     = if_tile_q;
      busy_o        = (state_q != S_IDLE);
      done_o        = (state_q == S_DONE);
   end

endmodule

// File: tb/tb_tile_loop_sequencer.sv
// tb_tile_loop_sequencer
//   Self-checking bench for tile_loop_sequencer. A reference model tracks the
//   run as a count of non-stalled cycles since start and derives every output
//   from tile/beat arithmetic. Table vectors add fixed latency and end-value
//   expectations; hand sequences cover stall, ignored start and reset mid-run.
module tb_tile_loop_sequencer;

   localparam int unsigned IDX_W  = 16;
   localparam int unsigned ADDR_W = 13;
   localparam int unsigned LEN_W  = 11;
   localparam int unsigned CNT_W  = 6;
   localparam int unsigned P      = 3;

   logic              clk_i, rst_ni, start_i, stall_i;
   logic [LEN_W-1:0]  cfg_tile_len_i;
   logic [CNT_W-1:0]  cfg_w_tiles_i, cfg_if_tiles_i;
   logic [IDX_W-1:0]  cfg_w_stride_i, cfg_wc_stride_i, cfg_if_stride_i;
   logic [ADDR_W-1:0] cfg_out_stride_i;
   logic              rd_en_o, acc_rd_en_o, wr_en_o, accumulate_o, busy_o, done_o;
   logic [IDX_W-1:0]  w_idx_o, if_idx_o;
   logic [ADDR_W-1:0] acc_rd_addr_o, wr_addr_o;
   logic [CNT_W-1:0]  w_tile_o, if_tile_o;

   tile_loop_sequencer #(
      .IDX_W(IDX_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .PIPE_LAT(P)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .stall_i(stall_i),
      .cfg_tile_len_i(cfg_tile_len_i), .cfg_w_tiles_i(cfg_w_tiles_i),
      .cfg_if_tiles_i(cfg_if_tiles_i), .cfg_w_stride_i(cfg_w_stride_i),
      .cfg_wc_stride_i(cfg_wc_stride_i), .cfg_if_stride_i(cfg_if_stride_i),
      .cfg_out_stride_i(cfg_out_stride_i),
      .rd_en_o(rd_en_o), .w_idx_o(w_idx_o), .if_idx_o(if_idx_o),
      .acc_rd_en_o(acc_rd_en_o), .acc_rd_addr_o(acc_rd_addr_o),
      .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .accumulate_o(accumulate_o),
      .w_tile_o(w_tile_o), .if_tile_o(if_tile_o), .busy_o(busy_o), .done_o(done_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      int L, Wt, It, ws, wcs, ifs, os;
      int exp_lat;   // cycles from start-accept edge to done_o
      int exp_w;     // w_idx_o after the run (held)
      int exp_wr;    // wr_addr_o after the run (held)
      int exp_nwr;   // wr_en_o beats in the run
   } vec_t;

   vec_t tbl[6];

   int checks = 0;
   int errors = 0;
   int ncyc   = 0;
   int obs_wr = 0;
   int obs_done = 0;
   logic last_done;

   // Reference model state
   bit  run;
   int  e, mL, mWt, mIt, mN;
   longint mws, mwcs, mifs, mos;
   logic [IDX_W-1:0]  hw, hi;
   logic [ADDR_W-1:0] hwa, hra;
   logic              hacc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, ncyc);
      end
   endtask

   task automatic model_reset();
      run = 1'b0; e = 0;
      hw = '0; hi = '0; hwa = '0; hra = '0; hacc = 1'b0;
   endtask

   task automatic check_outputs(input bit stall);
      logic ex_rd, ex_wr, ex_ard, ex_done;
      int   ewt, eit, per, t, ph;
      ex_rd = 0; ex_wr = 0; ex_ard = 0; ex_done = 0; ewt = 0; eit = 0;
      per = mL + P;
      if (run) begin
         ex_done = (e == mN);
         if (e < mN) begin
            t = e / per; ph = e % per;
            ewt = t % mWt; eit = t / mWt;
            if (ph < mL && !stall) begin
               ex_rd = 1;
               hw = IDX_W'(ewt * mws + eit * mwcs + ph);
               hi = IDX_W'(eit * mifs + ph);
            end
         end
         if (!stall && e >= P && e - P < mN) begin
            t = (e - P) / per; ph = (e - P) % per;
            if (ph < mL) begin
               ex_wr = 1;
               hwa  = ADDR_W'((t % mWt) * mos + ph);
               hacc = (t / mWt) != 0;
            end
         end
         if (!stall && e >= P - 1 && e - (P - 1) < mN) begin
            t = (e - (P - 1)) / per; ph = (e - (P - 1)) % per;
            if (ph < mL && (t / mWt) != 0) begin
               ex_ard = 1;
               hra = ADDR_W'((t % mWt) * mos + ph);
            end
         end
      end
      chk("rd_en", rd_en_o, ex_rd);
      chk("w_idx", w_idx_o, hw);
      chk("if_idx", if_idx_o, hi);
      chk("wr_en", wr_en_o, ex_wr);
      chk("wr_addr", wr_addr_o, hwa);
      chk("accumulate", accumulate_o, hacc);
      chk("acc_rd_en", acc_rd_en_o, ex_ard);
      chk("acc_rd_addr", acc_rd_addr_o, hra);
      chk("w_tile", w_tile_o, ewt);
      chk("if_tile", if_tile_o, eit);
      chk("busy", busy_o, run);
      chk("done", done_o, ex_done);
      if (wr_en_o === 1'b1) obs_wr++;
      if (done_o === 1'b1) obs_done++;
      last_done = done_o;
   endtask

   task automatic advance(input bit start, input bit stall);
      if (!run) begin
         if (start) begin
            run = 1'b1; e = 0;
            mL = int'(cfg_tile_len_i); mWt = int'(cfg_w_tiles_i); mIt = int'(cfg_if_tiles_i);
            mws = longint'(cfg_w_stride_i); mwcs = longint'(cfg_wc_stride_i);
            mifs = longint'(cfg_if_stride_i); mos = longint'(cfg_out_stride_i);
            mN = (mL == 0 || mWt == 0 || mIt == 0) ? 0 : mWt * mIt * (mL + P);
         end
      end else if (!stall) begin
         if (e == mN) run = 1'b0;
         else e++;
      end
   endtask

   task automatic cycle(input bit start, input bit stall);
      start_i = start; stall_i = stall;
      @(negedge clk_i);
      check_outputs(stall);
      @(posedge clk_i);
      advance(start, stall);
      ncyc++;
      #1;
   endtask

   task automatic set_cfg(input vec_t v);
      cfg_tile_len_i   = LEN_W'(v.L);   cfg_w_tiles_i   = CNT_W'(v.Wt);
      cfg_if_tiles_i   = CNT_W'(v.It);  cfg_w_stride_i  = IDX_W'(v.ws);
      cfg_wc_stride_i  = IDX_W'(v.wcs); cfg_if_stride_i = IDX_W'(v.ifs);
      cfg_out_stride_i = ADDR_W'(v.os);
   endtask

   task automatic scramble_cfg();
      cfg_tile_len_i   = LEN_W'($urandom_range(1, 9));
      cfg_w_tiles_i    = CNT_W'($urandom_range(1, 5));
      cfg_if_tiles_i   = CNT_W'($urandom_range(1, 5));
      cfg_w_stride_i   = IDX_W'($urandom);
      cfg_wc_stride_i  = IDX_W'($urandom);
      cfg_if_stride_i  = IDX_W'($urandom);
      cfg_out_stride_i = ADDR_W'($urandom);
   endtask

   // Accept a start with v, optionally stall and re-pulse start; returns the
   // accept-to-done latency, done pulse count and write beat count.
   task automatic run_vec(input vec_t v, input int stall_at, input int stall_len,
                          input bit inject_start, output int lat, output int ndone,
                          output int nwr);
      int  d0, w0, k;
      bit  seen, st, sp;
      set_cfg(v);
      cycle(1'b1, 1'b0);
      scramble_cfg();
      d0 = obs_done; w0 = obs_wr; lat = -1; seen = 0; k = 0;
      while (!seen && k < 500) begin
         st = (k >= stall_at) && (k < stall_at + stall_len);
         sp = inject_start && (k == 5);
         if (sp) scramble_cfg();
         cycle(sp, st);
         if (last_done === 1'b1) begin seen = 1; lat = k + 1; end
         k++;
      end
      if (!seen) chk("done_timeout", 1, 0);
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
      ndone = obs_done - d0;
      nwr   = obs_wr - w0;
   endtask

   initial begin
      int lat, nd, nw, guard;
      //        L  Wt It  ws      wcs  ifs  os      lat  w      wr  nwr
      tbl[0] = '{4, 2, 1, 16,     0,   0,   4,      15,  19,    7,  8};
      tbl[1] = '{4, 2, 2, 16,     64,  100, 4,      29,  83,    7,  16};
      tbl[2] = '{0, 3, 3, 1,      2,   3,   4,      1,   83,    7,  0};
      tbl[3] = '{1, 1, 2, 5,      7,   9,   3,      9,   7,     0,  2};
      tbl[4] = '{4, 3, 1, 'hFFFF, 0,   0,   'h1FFF, 22,  1,     1,  12};
      tbl[5] = '{5, 0, 2, 1,      1,   1,   1,      1,   1,     1,  0};

      rst_ni = 1'b0; start_i = 1'b0; stall_i = 1'b0;
      scramble_cfg();
      model_reset();
      #12;
      chk("reset_busy", busy_o, 0);
      chk("reset_done", done_o, 0);
      chk("reset_w_idx", w_idx_o, 0);
      chk("reset_wr_addr", wr_addr_o, 0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      cycle(1'b0, 1'b1);  // stall in IDLE is harmless

      foreach (tbl[i]) begin
         run_vec(tbl[i], 1000, 0, 1'b0, lat, nd, nw);
         chk($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
         chk($sformatf("vec%0d_ndone", i), nd, 1);
         chk($sformatf("vec%0d_nwr", i), nw, tbl[i].exp_nwr);
         chk($sformatf("vec%0d_last_w", i), w_idx_o, tbl[i].exp_w);
         chk($sformatf("vec%0d_last_wr", i), wr_addr_o, tbl[i].exp_wr);
      end

      // Three stall cycles mid-STREAM push done_o out by exactly three cycles
      run_vec(tbl[1], 2, 3, 1'b0, lat, nd, nw);
      chk("stall_lat", lat, 32);
      chk("stall_nwr", nw, 16);

      // Start pulsed while busy with a different config is ignored
      run_vec(tbl[0], 1000, 0, 1'b1, lat, nd, nw);
      chk("busy_start_lat", lat, 15);
      chk("busy_start_ndone", nd, 1);
      chk("busy_start_nwr", nw, 8);

      // Asynchronous reset in the first drain, then a clean rerun
      set_cfg(tbl[0]);
      cycle(1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0);
      #2 rst_ni = 1'b0;
      #1;
      model_reset();
      chk("rst_busy", busy_o, 0);
      chk("rst_rd_en", rd_en_o, 0);
      chk("rst_wr_en", wr_en_o, 0);
      chk("rst_w_idx", w_idx_o, 0);
      chk("rst_if_idx", if_idx_o, 0);
      chk("rst_wr_addr", wr_addr_o, 0);
      chk("rst_w_tile", w_tile_o, 0);
      @(negedge clk_i);
      chk("rst_done", done_o, 0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      run_vec(tbl[0], 1000, 0, 1'b0, lat, nd, nw);
      chk("post_rst_lat", lat, 15);
      chk("post_rst_ndone", nd, 1);
      chk("post_rst_last_w", w_idx_o, 19);

      // Randomized runs against the model, random stalls and stray starts
      for (int r = 0; r < 40; r++) begin
         cfg_tile_len_i   = LEN_W'($urandom_range(0, 6));
         cfg_w_tiles_i    = CNT_W'($urandom_range(0, 3));
         cfg_if_tiles_i   = CNT_W'($urandom_range(0, 3));
         cfg_w_stride_i   = IDX_W'($urandom);
         cfg_wc_stride_i  = IDX_W'($urandom);
         cfg_if_stride_i  = IDX_W'($urandom);
         cfg_out_stride_i = ADDR_W'($urandom);
         cycle(1'b1, ($urandom_range(0, 3) == 0));
         guard = 0;
         while (run && guard < 1000) begin
            if ($urandom_range(0, 7) == 0) scramble_cfg();
            cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0));
            guard++;
         end
         if (run) chk("rand_timeout", 1, 0);
         for (int i = 0; i < int'($urandom_range(0, 3)); i++)
            cycle(1'b0, ($urandom_range(0, 1) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
